// File: rtl/ray_dispatcher.sv
// Frame ray dispatcher: launches one ray per screen column, collects hit cells, strobes per-column results.
// Optional result buffer enabled by defining RAY_DISPATCHER_RESULT_BUFFER_EN.
module ray_dispatcher #(
    parameter int NUM_COLUMNS = 64,
    parameter int STEP_SHIFT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [13:0] player_x,
    input  logic [12:0] player_y,
    input  logic [7:0]  player_angle,
    output logic        busy,
    output logic        frame_done,
    output logic        ray_start,
    output logic [13:0] ray_x,
    output logic [12:0] ray_y,
    output logic [7:0]  ray_angle,
    input  logic        ray_done,
    input  logic [5:0]  ray_result_x,
    input  logic [4:0]  ray_result_y,
    output logic        col_valid,
    output logic [6:0]  col_index,
    output logic [5:0]  col_grid_x,
    output logic [4:0]  col_grid_y,
    input  logic [6:0]  rd_col,
    output logic [10:0] rd_data
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, EMIT, FINISH} state_t;

    localparam logic [7:0] HALF_SPAN = 8'((NUM_COLUMNS >> (STEP_SHIFT + 1)) % 256);
    localparam logic [6:0] LAST_COL  = 7'(NUM_COLUMNS - 1);

    state_t     state;
    state_t     state_next;
    logic [6:0] col;
    logic [6:0] col_next;
    logic [7:0] angle_base;
    logic [7:0] angle_step_next;

    assign col_next        = col + 7'd1;
    assign angle_step_next = 8'({1'b0, col_next} >> STEP_SHIFT);
    assign col_index       = col;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A launch is held off while ray_done is still high so the raytracer always sees a quiet cycle.
    always_comb begin
        state_next = state;
        ray_start  = 1'b0;
        busy       = (state != IDLE);
        col_valid  = (state == EMIT);
        frame_done = (state == FINISH);
        case (state)
            IDLE:      if (frame_start) state_next = LAUNCH;
            LAUNCH: begin
                if (!ray_done) begin
                    ray_start  = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: if (ray_done) state_next = EMIT;
            EMIT:      state_next = (col == LAST_COL) ? FINISH : LAUNCH;
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // ray_angle is registered so it reads 0 after reset and only moves between columns.
    always_ff @(posedge clock) begin
        if (reset) begin
            col        <= '0;
            angle_base <= '0;
            ray_x      <= '0;
            ray_y      <= '0;
            ray_angle  <= '0;
            col_grid_x <= '0;
            col_grid_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        ray_x      <= player_x;
                        ray_y      <= player_y;
                        angle_base <= player_angle - HALF_SPAN;
                        ray_angle  <= player_angle - HALF_SPAN;
                        col        <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (ray_done) begin
                        col_grid_x <= ray_result_x;
                        col_grid_y <= ray_result_y;
                    end
                end
                EMIT: begin
                    if (col != LAST_COL) begin
                        col       <= col_next;
                        ray_angle <= angle_base + angle_step_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RAY_DISPATCHER_RESULT_BUFFER_EN
    logic [10:0] result_mem [128];

    always_ff @(posedge clock) begin
        if (col_valid) begin
            result_mem[col_index] <= {col_grid_x, col_grid_y};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= result_mem[rd_col];
        end
    end
`else
    logic unused_rd_col;
    assign unused_rd_col = ^rd_col;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: randomized frames against a column/angle reference model.
module tb_ray_dispatcher;
    localparam int NC = 64;
    localparam int SS = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [13:0] player_x = '0;
    logic [12:0] player_y = '0;
    logic [7:0]  player_angle = '0;
    logic        ray_done = 1'b0;
    logic [5:0]  ray_result_x = '0;
    logic [4:0]  ray_result_y = '0;
    logic [6:0]  rd_col = '0;
    logic        busy, frame_done, ray_start, col_valid;
    logic [13:0] ray_x;
    logic [12:0] ray_y;
    logic [7:0]  ray_angle;
    logic [6:0]  col_index;
    logic [5:0]  col_grid_x;
    logic [4:0]  col_grid_y;
    logic [10:0] rd_data;

    ray_dispatcher #(.NUM_COLUMNS(NC), .STEP_SHIFT(SS)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .player_x(player_x), .player_y(player_y), .player_angle(player_angle),
        .busy(busy), .frame_done(frame_done), .ray_start(ray_start),
        .ray_x(ray_x), .ray_y(ray_y), .ray_angle(ray_angle),
        .ray_done(ray_done), .ray_result_x(ray_result_x), .ray_result_y(ray_result_y),
        .col_valid(col_valid), .col_index(col_index), .col_grid_x(col_grid_x),
        .col_grid_y(col_grid_y), .rd_col(rd_col), .rd_data(rd_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int   countdown = 0;
    int   launches = 0;
    int   frames_seen = 0;
    int   delay_min = 3;
    int   delay_max = 3;
    bit   fixed_y = 1'b0;
    logic busy_at_done = 1'b0;
    logic [5:0]  pend_x = '0;
    logic [4:0]  pend_y = '0;
    logic [7:0]  got_angle[$];
    logic [26:0] got_pos[$];
    logic [6:0]  got_idx[$];
    logic [10:0] got_grid[$];
    logic [10:0] resp[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then act as the raytracer for the next edge.
    task automatic step();
        logic s_start, s_valid, s_done;
        @(negedge clock);
        s_start = ray_start;
        s_valid = col_valid;
        s_done  = frame_done;
        if (s_start === 1'b1) begin
            check("ray_start_with_ray_done", 32'(ray_done), 32'd0);
            got_angle.push_back(ray_angle);
            got_pos.push_back({ray_x, ray_y});
        end
        if (s_valid === 1'b1) begin
            got_idx.push_back(col_index);
            got_grid.push_back({col_grid_x, col_grid_y});
        end
        if (s_done === 1'b1) begin
            frames_seen++;
            busy_at_done = busy;
        end
        ray_done = 1'b0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                ray_done     = 1'b1;
                ray_result_x = pend_x;
                ray_result_y = pend_y;
                resp.push_back({pend_x, pend_y});
            end
        end
        if (s_start === 1'b1) begin
            pend_x    = 6'(launches);
            pend_y    = fixed_y ? 5'd7 : 5'($urandom_range(0, 31));
            countdown = $urandom_range(delay_min, delay_max);
            launches++;
        end
    endtask

    task automatic clear_record();
        got_angle.delete();
        got_pos.delete();
        got_idx.delete();
        got_grid.delete();
        resp.delete();
        launches    = 0;
        frames_seen = 0;
        countdown   = 0;
    endtask

    task automatic run_frame(input logic [7:0] ang, input logic [13:0] px, input logic [12:0] py,
                             input int dmin, input int dmax, input bit inject, input bit fy);
        int budget;
        int exp_a;
        clear_record();
        delay_min    = dmin;
        delay_max    = dmax;
        fixed_y      = fy;
        player_x     = px;
        player_y     = py;
        player_angle = ang;
        frame_start  = 1'b1;
        step();
        frame_start  = 1'b0;
        player_angle = ~ang;
        check("busy_after_accept", 32'(busy), 32'd1);
        budget = 0;
        while (frames_seen == 0 && budget < 4000) begin
            if (inject && budget == 100) begin
                frame_start = 1'b1;
                player_x    = px ^ 14'h3fff;
            end else begin
                frame_start = 1'b0;
            end
            step();
            budget++;
        end
        frame_start = 1'b0;
        check("frame_done_count", 32'(frames_seen), 32'd1);
        check("busy_during_done", 32'(busy_at_done), 32'd1);
        step();
        check("idle_after_done", 32'({busy, frame_done, ray_start, col_valid}), 32'd0);
        check("ray_count", 32'(got_angle.size()), 32'(NC));
        check("col_count", 32'(got_idx.size()), 32'(NC));
        check("resp_count", 32'(resp.size()), 32'(NC));
        for (int i = 0; i < NC; i++) begin
            if (i < got_angle.size()) begin
                exp_a = ((int'(ang) - NC / (2 ** (SS + 1)) + i / (2 ** SS)) % 256 + 256) % 256;
                check("ray_angle", 32'(got_angle[i]), 32'(exp_a));
                check("ray_pos", 32'(got_pos[i]), 32'({px, py}));
            end
            if (i < got_idx.size() && i < resp.size()) begin
                check("col_index", 32'(got_idx[i]), 32'(i));
                check("col_grid", 32'(got_grid[i]), 32'(resp[i]));
            end
        end
    endtask

    initial begin
        int budget;
        int c;

        reset = 1'b1;
        step();
        step();
        check("rd_data_reset", 32'(rd_data), 32'd0);
        check("ctrl_reset", 32'({busy, frame_done, ray_start, col_valid}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ctrl_idle", 32'({busy, frame_done, ray_start, col_valid}), 32'd0);
            check("cols_idle", 32'({col_index, col_grid_x, col_grid_y}), 32'd0);
            check("pos_idle", 32'({ray_x, ray_y}), 32'd0);
            check("angle_idle", 32'(ray_angle), 32'd0);
`ifndef RAY_DISPATCHER_RESULT_BUFFER_EN
            check("rd_data_idle", 32'(rd_data), 32'd0);
`endif
        end
        check("no_launch_idle", 32'(launches), 32'd0);

        run_frame(8'd100, 14'h1234, 13'h0abc, 3, 3, 1'b0, 1'b1);

`ifdef RAY_DISPATCHER_RESULT_BUFFER_EN
        rd_col = 7'd12;
        step();
        check("rd_data_col12", 32'(rd_data), 32'({6'd12, 5'd7}));
        for (int k = 0; k < 6; k++) begin
            c = $urandom_range(0, NC - 1);
            rd_col = 7'(c);
            step();
            check("rd_data_rand", 32'(rd_data), 32'(resp[c]));
        end
`else
        rd_col = 7'd12;
        step();
        check("rd_data_off", 32'(rd_data), 32'd0);
        rd_col = 7'd127;
        step();
        check("rd_data_off", 32'(rd_data), 32'd0);
`endif

        run_frame(8'd5, 14'($urandom), 13'($urandom), 3, 3, 1'b0, 1'b0);
        run_frame(8'($urandom), 14'($urandom), 13'($urandom), 1, 5, 1'b1, 1'b0);

        clear_record();
        delay_min    = 3;
        delay_max    = 3;
        player_x     = 14'h2aaa;
        player_y     = 13'h1555;
        player_angle = 8'($urandom);
        frame_start  = 1'b1;
        step();
        frame_start  = 1'b0;
        budget = 0;
        while (!(launches == 11) && budget < 2000) begin
            step();
            budget++;
        end
        check("reached_col10", 32'(launches), 32'd11);
        step();
        reset     = 1'b1;
        countdown = 0;
        step();
        reset     = 1'b0;
        check("reset_midframe_ctrl", 32'({busy, frame_done, ray_start, col_valid}), 32'd0);
        check("reset_midframe_pos", 32'({ray_x, ray_y}), 32'd0);
        check("reset_midframe_angle", 32'(ray_angle), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("cols_before_reset", 32'(got_idx.size()), 32'd10);
        check("no_done_after_reset", 32'(frames_seen), 32'd0);
        check("busy_after_reset", 32'(busy), 32'd0);

        run_frame(8'($urandom), 14'($urandom), 13'($urandom), 1, 4, 1'b0, 1'b0);
        run_frame(8'($urandom), 14'($urandom), 13'($urandom), 1, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 SHALL have parameter NUM_COLUMNS, default 64, number of screen columns per frame (2..128).
REQ-002 SHALL have parameter STEP_SHIFT, default 1, log2 of columns per one-bytian angle step.
REQ-003 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_start  in  1  request to trace a frame; sampled only when idle.
REQ-006 SHALL have ports player_x  in  14, player_y  in  13, player_angle  in  8  viewpoint, captured at frame_start.
REQ-007 SHALL have port busy  out  1  high from the cycle after frame_start acceptance until frame_done.
REQ-008 SHALL have port frame_done  out  1  one-cycle pulse after the last column is emitted.
REQ-009 SHALL have ports ray_start  out  1, ray_x  out  14, ray_y  out  13, ray_angle  out  8  launch to the raytracer.
REQ-010 SHALL have ports ray_done  in  1, ray_result_x  in  6, ray_result_y  in  5  raytracer completion and hit cell.
REQ-011 SHALL have ports col_valid  out  1, col_index  out  7, col_grid_x  out  6, col_grid_y  out  5  per-column result strobe.
REQ-012 SHALL have ports rd_col  in  7, rd_data  out  11  result-buffer read port ({grid_x, grid_y}).

Function
REQ-013 SHALL implement states IDLE, LAUNCH, WAIT_DONE, EMIT, FINISH.
REQ-014 IDLE: on frame_start=1 SHALL latch player_x/y/angle, clear column counter to 0, go to LAUNCH; otherwise stay.
REQ-015 LAUNCH: SHALL assert ray_start for exactly this one cycle, then go to WAIT_DONE.
REQ-016 ray_x/ray_y SHALL equal latched player_x/y throughout the frame.
REQ-017 ray_angle SHALL equal (latched_angle - (NUM_COLUMNS >> (STEP_SHIFT+1)) + (col >> STEP_SHIFT)) mod 256, stable from LAUNCH through WAIT_DONE.
REQ-018 WAIT_DONE: SHALL wait indefinitely; on ray_done=1 SHALL capture ray_result_x/y in that same cycle and go to EMIT.
REQ-019 EMIT: SHALL assert col_valid for one cycle with col_index = current column and captured grid values; if col = NUM_COLUMNS-1 go to FINISH, else increment col and go to LAUNCH.
REQ-020 FINISH: SHALL assert frame_done for one cycle, then return to IDLE.
REQ-021 ray_start SHALL never be asserted in a cycle where ray_done=1, guaranteeing at least one cycle for the raytracer to return to its wait state.
REQ-022 frame_start while not in IDLE SHALL be ignored; latched viewpoint SHALL not change mid-frame.
REQ-023 ray_done outside WAIT_DONE SHALL be ignored.
REQ-024 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-025 Column counter SHALL be 7 bits; angle arithmetic SHALL wrap modulo 256 without saturation.

Reset
REQ-026 reset SHALL take priority over all inputs and force state IDLE in the next cycle, including mid-frame.
REQ-027 After reset SHALL hold busy, frame_done, ray_start, col_valid = 0; col_index, col_grid_x, col_grid_y, ray_x, ray_y, ray_angle, rd_data = 0.

Configuration
REQ-028 Macro RAY_DISPATCHER_RESULT_BUFFER_EN SHALL control the result buffer.
REQ-029 Defined: SHALL write {col_grid_x, col_grid_y} to entry col_index on each col_valid; rd_data SHALL return entry rd_col one cycle after rd_col is presented; a same-cycle write and read of one entry SHALL return the old value; entries are not cleared by reset and are undefined until written.
REQ-030 Not defined: no storage SHALL be inferred; rd_data SHALL be constant 0; rd_col ignored.

Verification
REQ-031 Reset, idle 5 cycles -> all outputs 0, no ray_start.
REQ-032 frame_start with player_angle=8'd100, NUM_COLUMNS=64, STEP_SHIFT=1; model answers ray_done 3 cycles after each ray_start -> 64 ray_starts, angles 84,84,85,...,115, 64 col_valid with col_index 0..63, one frame_done, busy drops with it.
REQ-033 player_angle=8'd5 -> first ray_angle 8'd245, wraps through 255 to 0, last 8'd20.
REQ-034 frame_start pulsed again mid-frame with player_x changed -> ignored; ray_x unchanged; column count stays 64.
REQ-035 reset asserted while in WAIT_DONE on column 10 -> IDLE next cycle, no col_valid, no frame_done; new frame_start restarts at col 0.
REQ-036 With RAY_DISPATCHER_RESULT_BUFFER_EN, model returns result_x=col[5:0], result_y=5'd7 -> after frame_done, rd_col=7'd12 yields rd_data={6'd12,5'd7} one cycle later; without macro rd_data=0.
